// File: rtl/leds_pkg.sv
// Shared register map, CTRL bit positions and STATUS layout for the LED PWM block.
package leds_pkg;

  localparam int unsigned BUS_W      = 32;
  localparam int unsigned PRESCALE_W = 16;
  localparam int unsigned BLINK_W    = 16;

  // Byte offsets from the base of the register window
  localparam int unsigned REG_CTRL     = 32'h0;
  localparam int unsigned REG_PRESCALE = 32'h4;
  localparam int unsigned REG_BLINK    = 32'h8;
  localparam int unsigned REG_STATUS   = 32'hC;
  localparam int unsigned REG_DUTY     = 32'h10;

  // CTRL bits
  localparam int unsigned CTRL_ENABLE   = 0;
  localparam int unsigned CTRL_BLINK_EN = 1;
  localparam int unsigned CTRL_INVERT   = 2;
  localparam int unsigned CTRL_W        = 3;

  // STATUS layout
  localparam int unsigned STATUS_PHASE   = 0;
  localparam int unsigned STATUS_CNT_LSB = 16;

  // Replace the byte lanes of cur selected by mask with those of wdata
  function automatic logic [BUS_W-1:0] lane_merge(input logic [BUS_W-1:0] cur,
                                                  input logic [BUS_W-1:0] wdata,
                                                  input logic [3:0]       mask);
    logic [BUS_W-1:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/leds_pwm_channel.sv
// One LED channel: period-aligned shadow duty, compare against the shared PWM count, output register.
module leds_pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [PWM_BITS-1:0] duty,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                gate,
  input  logic                invert,
  output logic                led
);

  logic [PWM_BITS-1:0] shadow;

  // Shadow duty follows DUTY only at period boundaries (or while disabled); LED is registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      led    <= 1'b0;
    end else begin
      if (load) shadow <= duty;
      led <= invert ^ (gate & (pwm_cnt < shadow));
    end
  end

endmodule

// File: rtl/leds_pwm_controller.sv
// Multi-channel LED PWM controller with prescaler, blink gating and a simple strobe-based register bus.
module leds_pwm_controller
  import leds_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned PWM_BITS  = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [CHANNELS-1:0] leds,
  input  logic [31:0]         addr_bus,
  inout  wire  [31:0]         data_bus,
  input  logic                rd_bus,
  input  logic                wr_bus,
  input  logic [3:0]          data_mask_bus,
  output wire                 fc_bus
);

  localparam int unsigned WORD_W = BUS_W - 2;

  logic [CTRL_W-1:0]     ctrl;
  logic [PRESCALE_W-1:0] prescale;
  logic [BLINK_W-1:0]    blink;
  logic [PWM_BITS-1:0]   duty [CHANNELS];
  logic                  wr_done;

  logic [PRESCALE_W-1:0] presc_cnt;
  logic [PWM_BITS-1:0]   pwm_cnt;
  logic [BLINK_W-1:0]    blink_cnt;
  logic [BLINK_W-1:0]    blink_next;
  logic                  blink_phase;
  logic                  blink_force;
  logic                  enable;
  logic                  tick;
  logic                  wrap;

  logic [BUS_W-1:0]  offset;
  logic [WORD_W-1:0] word;
  logic              is_ctrl, is_prescale, is_blink, is_status, is_duty;
  logic              hit, rd_ok, wr_req, wr_fire;
  logic [BUS_W-1:0]  rdata;

  // Address decode relative to the window base
  assign offset      = addr_bus - BASE_ADDR;
  assign word        = offset[BUS_W-1:2];
  assign is_ctrl     = (word == WORD_W'(REG_CTRL >> 2));
  assign is_prescale = (word == WORD_W'(REG_PRESCALE >> 2));
  assign is_blink    = (word == WORD_W'(REG_BLINK >> 2));
  assign is_status   = (word == WORD_W'(REG_STATUS >> 2));
  assign is_duty     = (word >= WORD_W'(REG_DUTY >> 2)) &&
                       (word <  WORD_W'((REG_DUTY >> 2) + CHANNELS));
  assign hit         = (offset[1:0] == 2'b00) &&
                       (is_ctrl || is_prescale || is_blink || is_status || is_duty);

  assign rd_ok   = hit && rd_bus && !wr_bus;
  assign wr_req  = hit && wr_bus && !rd_bus;
  assign wr_fire = wr_req && !wr_done;

  assign enable      = ctrl[CTRL_ENABLE];
  assign tick        = enable && (presc_cnt == prescale);
  assign wrap        = tick && (pwm_cnt == '1);
  assign blink_force = (blink == '0) || !ctrl[CTRL_BLINK_EN];
  assign blink_next  = blink_cnt + BLINK_W'(1);

  // Register writes: one update per strobe, completion flag held until the strobe drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl     <= '0;
      prescale <= '0;
      blink    <= '0;
      wr_done  <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) duty[i] <= '0;
    end else begin
      wr_done <= wr_req;
      if (wr_fire) begin
        if (is_ctrl)
          ctrl <= CTRL_W'(lane_merge(BUS_W'(ctrl), data_bus, data_mask_bus));
        if (is_prescale)
          prescale <= PRESCALE_W'(lane_merge(BUS_W'(prescale), data_bus, data_mask_bus));
        if (is_blink)
          blink <= BLINK_W'(lane_merge(BUS_W'(blink), data_bus, data_mask_bus));
        for (int i = 0; i < CHANNELS; i++) begin
          if (word == WORD_W'((REG_DUTY >> 2) + i))
            duty[i] <= PWM_BITS'(lane_merge(BUS_W'(duty[i]), data_bus, data_mask_bus));
        end
      end
    end
  end

  // Prescaler and PWM counter; prescaler free-runs through 16'hFFFF if PRESCALE drops below it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else if (!enable) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_W'(1);
      if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  // Blink phase toggles every BLINK period boundaries; held on when blinking is off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (blink_force) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wrap) begin
      if (blink_next == blink) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_next;
      end
    end
  end

  // Read-data mux, zero-extended
  always_comb begin
    rdata = '0;
    if (is_ctrl)     rdata = BUS_W'(ctrl);
    if (is_prescale) rdata = BUS_W'(prescale);
    if (is_blink)    rdata = BUS_W'(blink);
    if (is_status) begin
      rdata[STATUS_PHASE]               = blink_phase;
      rdata[STATUS_CNT_LSB +: PWM_BITS] = pwm_cnt;
    end
    for (int i = 0; i < CHANNELS; i++) begin
      if (word == WORD_W'((REG_DUTY >> 2) + i)) rdata = BUS_W'(duty[i]);
    end
  end

  assign data_bus = rd_ok ? rdata : 32'bz;
  assign fc_bus   = (rd_ok || wr_req) ? (rd_ok || wr_done) : 1'bz;

  // Per-channel shadow, compare and output register
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    leds_pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (wrap || !enable),
      .duty    (duty[gi]),
      .pwm_cnt (pwm_cnt),
      .gate    (enable && blink_phase),
      .invert  (ctrl[CTRL_INVERT]),
      .led     (leds[gi])
    );
  end

endmodule

// File: tb/tb_leds_pwm_controller.sv
// Bench for leds_pwm_controller: bus handshake, register map, PWM duty, blink and prescaler behaviour.
module tb_leds_pwm_controller;

  localparam int unsigned CH   = 4;
  localparam int unsigned PB   = 8;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] leds;
  logic [31:0]   addr;
  wire  [31:0]   data_bus;
  logic          rd, wr;
  logic [3:0]    mask;
  wire           fc_bus;
  logic          drv_en;
  logic [31:0]   drv_data;

  int checks = 0;
  int errors = 0;

  // An undriven bus reads as all ones, so "not driven" is observable as 1s
  assign data_bus = drv_en ? drv_data : 32'bz;
  pullup pu_data (data_bus);
  pullup pu_fc (fc_bus);

  always #5 clk = ~clk;

  leds_pwm_controller #(.CHANNELS(CH), .PWM_BITS(PB), .BASE_ADDR(BASE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .leds          (leds),
    .addr_bus      (addr),
    .data_bus      (data_bus),
    .rd_bus        (rd),
    .wr_bus        (wr),
    .data_mask_bus (mask),
    .fc_bus        (fc_bus)
  );

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                           output logic fc_pre, output logic fc_post);
    @(negedge clk);
    addr = a; drv_data = d; drv_en = 1'b1; mask = m; wr = 1'b1;
    #1 fc_pre = fc_bus;
    @(posedge clk);
    #1 fc_post = fc_bus;
    @(negedge clk);
    wr = 1'b0; drv_en = 1'b0; mask = 4'h0;
  endtask

  task automatic wr32(input logic [31:0] off, input logic [31:0] d);
    logic f0, f1;
    bus_write(BASE + off, d, 4'hF, f0, f1);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic fc);
    @(negedge clk);
    addr = a; rd = 1'b1;
    #1 d = data_bus; fc = fc_bus;
    rd = 1'b0;
  endtask

  // Poll STATUS until the PWM count sits mid-period (prescale 0 assumed)
  task automatic find_mid(output int unsigned c);
    logic [31:0] d; logic fc; bit found;
    found = 1'b0; c = 0;
    for (int k = 0; k < 600 && !found; k++) begin
      bus_read(BASE + 32'hC, d, fc);
      c = int'(d[23:16]);
      if (c >= 10 && c <= 200) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL find_mid: pwm count last %0d, required within 10..200", c);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic fc;
    logic [31:0] offs [8];
    logic [31:0] exps [8];
    offs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C};
    exps = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; drv_en = 1'b0; drv_data = '0; addr = '0; mask = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (leds !== '0) begin
      errors++; $display("FAIL reset_leds: got %b required 0", leds);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE + offs[i], d, fc);
      checks++;
      if (d !== exps[i] || fc !== 1'b1) begin
        errors++;
        $display("FAIL reset_reg_%0h: data %h fc %b required %h fc 1", offs[i], d, fc, exps[i]);
      end
    end
  endtask

  task automatic test_bus();
    logic [31:0] d, v, dat; logic fc, f0, f1; logic [3:0] m; int unsigned s;
    logic [31:0] mdl [7];
    logic [31:0] offs [7];
    logic [31:0] wm [7];
    offs = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h14, 32'h18, 32'h1C};
    wm   = '{32'h7, 32'hFFFF, 32'hFFFF, 32'hFF, 32'hFF, 32'hFF, 32'hFF};
    mdl  = '{default: 32'h0};
    bus_write(BASE + 32'h10, 32'h1234_5678, 4'b0001, f0, f1);
    checks++;
    if (f0 !== 1'b0 || f1 !== 1'b1) begin
      errors++; $display("FAIL write_fc: before edge %b after edge %b required 0 then 1", f0, f1);
    end
    mdl[3] = 32'h78;
    bus_read(BASE + 32'h10, d, fc);
    checks++;
    if (d !== 32'h78 || fc !== 1'b1) begin
      errors++; $display("FAIL masked_write_read: data %h fc %b required 00000078 fc 1", d, fc);
    end
    for (int it = 0; it < 10; it++) begin
      s = $urandom_range(0, 6);
      dat = $urandom; m = 4'($urandom_range(0, 15));
      bus_write(BASE + offs[s], dat, m, f0, f1);
      v = mdl[s];
      for (int b = 0; b < 4; b++) if (m[b]) v[8*b +: 8] = dat[8*b +: 8];
      mdl[s] = v & wm[s];
      bus_read(BASE + offs[s], d, fc);
      checks++;
      if (d !== mdl[s] || fc !== 1'b1) begin
        errors++;
        $display("FAIL rand_rw_%0h: data %h fc %b required %h fc 1", offs[s], d, fc, mdl[s]);
      end
    end
    wr32(32'h0, 32'h0);
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, f0, f1);
    bus_read(BASE + 32'hC, d, fc);
    checks++;
    if (f1 !== 1'b1 || d !== 32'h1) begin
      errors++; $display("FAIL status_write: fc %b read %h required fc 1 read 00000001", f1, d);
    end
    bus_read(BASE + 32'h40, d, fc);
    checks++;
    if (d !== 32'hFFFF_FFFF || fc !== 1'b1) begin
      errors++; $display("FAIL unmapped_40: data %h fc %b required undriven", d, fc);
    end
    bus_read(BASE + 32'h2, d, fc);
    checks++;
    if (d !== 32'hFFFF_FFFF || fc !== 1'b1) begin
      errors++; $display("FAIL unaligned_2: data %h fc %b required undriven", d, fc);
    end
    bus_read(BASE - 32'h4, d, fc);
    checks++;
    if (d !== 32'hFFFF_FFFF || fc !== 1'b1) begin
      errors++; $display("FAIL below_base: data %h fc %b required undriven", d, fc);
    end
    @(negedge clk);
    addr = BASE + 32'h10; rd = 1'b1; wr = 1'b1; drv_en = 1'b0;
    #1 d = data_bus; fc = fc_bus;
    rd = 1'b0; wr = 1'b0;
    checks++;
    if (d !== 32'hFFFF_FFFF || fc !== 1'b1) begin
      errors++; $display("FAIL both_strobes: data %h fc %b required undriven", d, fc);
    end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d; logic fc;
    @(negedge clk);
    addr = BASE + 32'h14; drv_data = 32'hAB; drv_en = 1'b1; mask = 4'hF; wr = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; drv_en = 1'b0; mask = 4'h0;
    rst_n = 1'b1;
    bus_read(BASE + 32'h14, d, fc);
    checks++;
    if (d !== 32'h0) begin
      errors++; $display("FAIL reset_discard: DUTY1 %h required 00000000", d);
    end
    wr32(32'h14, 32'h5A);
    bus_read(BASE + 32'h14, d, fc);
    checks++;
    if (d !== 32'h5A) begin
      errors++; $display("FAIL write_after_reset: DUTY1 %h required 0000005a", d);
    end
  endtask

  // Any window of one full PWM period holds exactly duty*(PRESCALE+1) high clocks
  task automatic test_duty();
    for (int it = 0; it < 3; it++) begin
      int unsigned p;
      int unsigned dty [CH];
      int unsigned hi  [CH];
      p      = (it == 0) ? 0 : $urandom_range(0, 3);
      dty[0] = (it == 0) ? 64 : $urandom_range(0, 255);
      dty[1] = 0;
      dty[2] = 255;
      dty[3] = $urandom_range(1, 254);
      wr32(32'h0, 32'h0);
      wr32(32'h4, 32'(p));
      wr32(32'h8, 32'h0);
      for (int i = 0; i < CH; i++) wr32(32'(16 + 4 * i), 32'(dty[i]));
      wr32(32'h0, 32'h1);
      repeat (4) @(negedge clk);
      hi = '{default: 0};
      for (int k = 0; k < 256 * (p + 1); k++) begin
        @(negedge clk);
        #1;
        for (int i = 0; i < CH; i++) if (leds[i]) hi[i]++;
      end
      for (int i = 0; i < CH; i++) begin
        checks++;
        if (hi[i] !== dty[i] * (p + 1)) begin
          errors++;
          $display("FAIL duty_ch%0d_it%0d: high %0d clocks required %0d (duty %0d prescale %0d)",
                   i, it, hi[i], dty[i] * (p + 1), dty[i], p);
        end
      end
    end
  endtask

  // Rewriting DUTY mid-period must not take effect until the next period
  task automatic test_duty_change();
    int unsigned c, j, t, sh, bad, first_j; logic expv;
    wr32(32'h0, 32'h0);
    wr32(32'h4, 32'h0);
    wr32(32'h8, 32'h0);
    wr32(32'h10, 32'd64);
    wr32(32'h0, 32'h1);
    find_mid(c);
    wr32(32'h10, 32'd192);
    j = 2; bad = 0; first_j = 0;
    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      #1;
      j++;
      t    = c + j - 1;
      sh   = (t / 256 == 0) ? 64 : 192;
      expv = ((t % 256) < sh);
      if (leds[0] !== expv) begin
        if (bad == 0) first_j = j;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL duty_change: %0d wrong samples, first at offset %0d (start count %0d)", bad, first_j, c);
    end
  endtask

  // Blink with invert: alternate 2-period windows are forced all-ones
  task automatic test_blink();
    int unsigned c, j, t, bad, first_j;
    int unsigned dty [CH];
    logic ph; logic [CH-1:0] expv, got_first, exp_first;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dty = '{100, 0, 100, $urandom_range(1, 255)};
    wr32(32'h4, 32'h0);
    wr32(32'h8, 32'h2);
    for (int i = 0; i < CH; i++) wr32(32'(16 + 4 * i), 32'(dty[i]));
    wr32(32'h0, 32'h1);
    find_mid(c);
    wr32(32'h0, 32'h7);
    j = 2; bad = 0; first_j = 0; got_first = '0; exp_first = '0;
    for (int k = 0; k < 2048; k++) begin
      @(negedge clk);
      #1;
      j++;
      t  = c + j - 1;
      ph = (((t / 256) / 2) % 2) == 0;
      for (int i = 0; i < CH; i++) expv[i] = 1'b1 ^ (ph && ((t % 256) < dty[i]));
      if (leds !== expv) begin
        if (bad == 0) begin first_j = j; got_first = leds; exp_first = expv; end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL blink_invert: %0d wrong samples, first at offset %0d got %b required %b",
               bad, first_j, got_first, exp_first);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] d; logic fc; int unsigned p, e;
    wr32(32'h0, 32'h0);
    bus_read(BASE + 32'hC, d, fc);
    checks++;
    if (d !== 32'h1) begin
      errors++; $display("FAIL disabled_status: %h required 00000001", d);
    end
    for (int it = 0; it < 2; it++) begin
      p = $urandom_range(0, 5);
      wr32(32'h0, 32'h0);
      wr32(32'h4, 32'(p));
      wr32(32'h0, 32'h1);
      repeat (40) @(negedge clk);
      bus_read(BASE + 32'hC, d, fc);
      e = 41 / (p + 1);
      checks++;
      if (d[23:16] !== 8'(e)) begin
        errors++; $display("FAIL prescale_%0d: pwm count %0d required %0d", p, d[23:16], e);
      end
    end
    wr32(32'h0, 32'h0);
    wr32(32'h4, 32'd1000);
    wr32(32'h0, 32'h1);
    repeat (600) @(negedge clk);
    bus_read(BASE + 32'hC, d, fc);
    checks++;
    if (d[23:16] !== 8'd0) begin
      errors++; $display("FAIL prescale_1000: pwm count %0d required 0", d[23:16]);
    end
    wr32(32'h4, 32'd10);
    repeat (1000) @(negedge clk);
    bus_read(BASE + 32'hC, d, fc);
    checks++;
    if (d[23:16] !== 8'd0) begin
      errors++; $display("FAIL prescale_lowered: pwm count %0d required 0", d[23:16]);
    end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_reset_mid_write();
    test_duty();
    test_duty_change();
    test_blink();
    test_prescale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
